combo_seq_checker: RTL

//  Drives the a/b/c/d inputs of the Task 2 sequential top (combo + dff + 2:1 mux) and checks its f output.
//  It generates pseudo-random vectors, runs a cycle-accurate golden model, and compares f every cycle.
//  It reports pass/fail, an error count and the index of the first error.
//  It sits on the stimulus side of that top, in the same clock domain.

---
 rtl/project1_pkg.sv | 21 ++
 rtl/combo_ref_model.sv | 39 +++
 rtl/combo_seq_checker.sv | 133 +++++++++++++
 3 files changed

// File: rtl/project1_pkg.sv
// rtl/project1_pkg.sv - shared types and constants for the combo sequence checker
package project1_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Feedback taps for x^8+x^6+x^5+x^4+1 on a left-shifting register (bits 7,5,4,3).
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  // a=1, b=c=d=0: h=g=0 so f=0 regardless of the DUT flop, and n=1 loads the flop with 1.
  localparam logic [3:0] SYNC_VEC = 4'b1000;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/combo_ref_model.sv
// rtl/combo_ref_model.sv - cycle-accurate reference of the combo + flop + mux top
module combo_ref_model
  import project1_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  input  logic d_i,
  output logic f_exp_o
);

  logic k_q, k_d;
  logic h, g, n;

  // Combinational part of the reference: same equations as the DUT.
  always_comb begin
    h       = ~(a_i | b_i);
    g       = b_i & c_i;
    n       = ~(c_i & d_i);
    f_exp_o = k_q ? h : g;
    k_d     = k_q;
    if (en_i) begin
      k_d = n ^ f_exp_o;
    end
  end

  // Model flop advances on the expected f only, so DUT errors never leak into later checks.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      k_q <= 1'b0;
    end else begin
      k_q <= k_d;
    end
  end

endmodule

// File: rtl/combo_seq_checker.sv
// rtl/combo_seq_checker.sv - stimulus generator and scoreboard for the combo sequential top
module combo_seq_checker
  import project1_pkg::*;
#(
  parameter int         NUM_VEC   = 64,
  parameter logic [7:0] LFSR_SEED = 8'hA5,
  parameter int         ERR_W     = 8,
  parameter int         IDX_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             f_in,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [IDX_W-1:0] first_err_idx
);

  localparam int              CNT_W    = $clog2(NUM_VEC + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VEC - 1);

  state_e           state_q, state_d;
  logic [3:0]       abcd_q, abcd_d;
  logic [7:0]       lfsr_q, lfsr_d, lfsr_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [IDX_W-1:0] fidx_q, fidx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             checking;
  logic             f_exp;
  logic             mismatch;

  assign checking = (state_q == ST_SYNC) || (state_q == ST_RUN);
  assign mismatch = checking && (f_in != f_exp);
  assign lfsr_nxt = lfsr_step(lfsr_q);

  combo_ref_model u_ref (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .en_i    (checking),
    .a_i     (abcd_q[3]),
    .b_i     (abcd_q[2]),
    .c_i     (abcd_q[1]),
    .d_i     (abcd_q[0]),
    .f_exp_o (f_exp)
  );

  // Run sequencing, stimulus selection and error scoreboard.
  always_comb begin
    state_d = state_q;
    abcd_d  = abcd_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fidx_d  = fidx_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_SYNC;
          abcd_d  = SYNC_VEC;
          lfsr_d  = LFSR_SEED;
          cnt_d   = '0;
          err_d   = '0;
          fidx_d  = '0;
        end
      end
      ST_SYNC: begin
        state_d = ST_RUN;
        abcd_d  = lfsr_q[3:0];
      end
      ST_RUN: begin
        lfsr_d = lfsr_nxt;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = ST_DONE;
          abcd_d  = 4'b0000;
        end else begin
          abcd_d = lfsr_nxt[3:0];
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A SYNC mismatch reports index 0 without consuming a vector.
    if (mismatch) begin
      if (err_q == '0) begin
        fidx_d = (state_q == ST_RUN) ? IDX_W'(cnt_q) : '0;
      end
      if (err_q != '1) begin
        err_d = err_q + 1'b1;
      end
    end
    busy_d = (state_d == ST_SYNC) || (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State and result registers; reset aborts any run and discards its results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      abcd_q  <= 4'b0000;
      lfsr_q  <= LFSR_SEED;
      cnt_q   <= '0;
      err_q   <= '0;
      fidx_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      abcd_q  <= abcd_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fidx_q  <= fidx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign {a, b, c, d}   = abcd_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = done_q && (err_q == '0);
  assign err_count      = err_q;
  assign first_err_idx  = fidx_q;

endmodule
